// File: rtl/panel_pkg.sv
// panel_pkg: shared state encodings, device register constants and the
// seven-segment lookup used by the panel_scan front-panel scanner.
package panel_pkg;

   // Scan sequencer states, visited in this order after reset.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_DIR,
      ST_INIT_PU,
      ST_INIT_DISP,
      ST_SNAP,
      ST_WR_EXP,
      ST_WR_DIG,
      ST_RD_EXP
   } state_e;

   // Per-index transaction phase: decide, offer request, await response.
   typedef enum logic [1:0] {
      PH_ISSUE,
      PH_REQ,
      PH_RSP
   } phase_e;

   // MCP23017 registers (IOCON.BANK = 0 layout).
   localparam logic [7:0] IODIRB = 8'h01;
   localparam logic [7:0] GPPUA  = 8'h0C;
   localparam logic [7:0] GPIOA  = 8'h12;
   localparam logic [7:0] OLATB  = 8'h15;

   // HT16K33 command byte and the data byte that enables oscillator and display.
   localparam logic [7:0] HT_ON_CMD  = 8'h21;
   localparam logic [7:0] HT_ON_DATA = 8'h81;

   // Storage is sized for the largest supported panel so a 3-bit index
   // always addresses it exactly.
   localparam int MAX_UNITS = 8;

   // Hex nibble to 7-segment code (bit 0 = segment a).
   function automatic logic [7:0] seg7(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0: seg = 8'h3F;
         4'h1: seg = 8'h06;
         4'h2: seg = 8'h5B;
         4'h3: seg = 8'h4F;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'h6D;
         4'h6: seg = 8'h7D;
         4'h7: seg = 8'h07;
         4'h8: seg = 8'h7F;
         4'h9: seg = 8'h6F;
         4'hA: seg = 8'h77;
         4'hB: seg = 8'h7C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h5E;
         4'hE: seg = 8'h79;
         4'hF: seg = 8'h71;
         default: seg = 8'h00;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/panel_seg7.sv
// panel_seg7: combinational nibble to seven-segment encoder.
module panel_seg7
   import panel_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [7:0] seg_o
);

   // Table lookup shared with any other user of the package.
   always_comb seg_o = seg7(nib_i);

endmodule

// File: rtl/panel_scan.sv
// panel_scan: sequences MCP23017 expanders and an HT16K33 display through a
// request/response byte-level I2C master: init, then snapshot, dirty-only
// writes and a full switch read pass, repeated forever.
module panel_scan
   import panel_pkg::*;
#(
   parameter int         N_EXP     = 4,
   parameter int         N_DIG     = 4,
   parameter logic [6:0] EXP_BASE  = 7'h20,
   parameter logic [6:0] DISP_ADDR = 7'h70,
   parameter int         MAX_RETRY = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [8*N_EXP-1:0] gpio_i,
   input  logic [4*N_DIG-1:0] lcd_bcd_i,
   output logic [8*N_EXP-1:0] gpio_o,
   output logic               gpio_vld_o,
   output logic               err_o,
   output logic               req_val_o,
   input  logic               req_rdy_i,
   output logic [6:0]         req_daddr_o,
   output logic [7:0]         req_addr_o,
   output logic [7:0]         req_data_o,
   output logic               req_wen_o,
   input  logic               rsp_val_i,
   output logic               rsp_rdy_o,
   input  logic               rsp_err_i,
   input  logic [7:0]         rsp_data_i
);

   localparam logic [2:0] EXP_LAST = 3'(N_EXP - 1);
   localparam logic [2:0] DIG_LAST = 3'(N_DIG - 1);

   state_e               state_q, state_d;
   phase_e               phase_q, phase_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           retry_q, retry_d;
   logic                 err_q, err_d;
   logic                 vld_q, vld_d;
   logic [8*N_EXP-1:0]   gpio_q, gpio_d;
   logic [MAX_UNITS-1:0] exp_ok_q, dig_ok_q;
   logic [7:0]           snap_exp_q   [MAX_UNITS];
   logic [3:0]           snap_dig_q   [MAX_UNITS];
   logic [7:0]           exp_shadow_q [MAX_UNITS];
   logic [3:0]           dig_shadow_q [MAX_UNITS];
   logic [7:0]           stage_q      [MAX_UNITS];
   logic [7:0]           seg_code;
   logic [2:0]           last_idx;
   logic                 need, commit, advance, inval;

   panel_seg7 u_seg7 (
      .nib_i (snap_dig_q[idx_q]),
      .seg_o (seg_code)
   );

   assign req_val_o  = (phase_q == PH_REQ);
   assign rsp_rdy_o  = (phase_q == PH_RSP);
   assign gpio_o     = gpio_q;
   assign gpio_vld_o = vld_q;
   assign err_o      = err_q;

   // Decode the current index: whether it needs a bus transaction and what that transaction is.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      need        = 1'b0;
      last_idx    = EXP_LAST;
      req_daddr_o = EXP_BASE + 7'(idx_q);
      req_addr_o  = 8'h00;
      req_data_o  = 8'h00;
      req_wen_o   = 1'b1;
      case (state_q)
         ST_INIT_DIR: begin
            need       = 1'b1;
            req_addr_o = IODIRB;
         end
         ST_INIT_PU: begin
            need       = 1'b1;
            req_addr_o = GPPUA;
            req_data_o = 8'hFF;
         end
         ST_INIT_DISP: begin
            need        = 1'b1;
            last_idx    = 3'd0;
            req_daddr_o = DISP_ADDR;
            req_addr_o  = HT_ON_CMD;
            req_data_o  = HT_ON_DATA;
         end
         ST_WR_EXP: begin
            need       = !exp_ok_q[idx_q] || (exp_shadow_q[idx_q] != snap_exp_q[idx_q]);
            req_addr_o = OLATB;
            req_data_o = snap_exp_q[idx_q];
         end
         ST_WR_DIG: begin
            need        = !dig_ok_q[idx_q] || (dig_shadow_q[idx_q] != snap_dig_q[idx_q]);
            last_idx    = DIG_LAST;
            req_daddr_o = DISP_ADDR;
            req_addr_o  = {4'h0, idx_q, 1'b0};
            req_data_o  = seg_code;
         end
         ST_RD_EXP: begin
            need       = 1'b1;
            req_addr_o = GPIOA;
            req_wen_o  = 1'b0;
         end
         default: ;
      endcase
   end

   // Next-state logic: handshake phases, retry/abandon on error, index and state advance.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      retry_d = retry_q;
      err_d   = err_q;
      vld_d   = 1'b0;
      commit  = 1'b0;
      advance = 1'b0;
      inval   = 1'b0;
      case (phase_q)
         PH_ISSUE: begin
            if (state_q == ST_IDLE) begin
               state_d = ST_INIT_DIR;
               idx_d   = 3'd0;
               inval   = 1'b1;
            end else if (state_q == ST_SNAP) begin
               state_d = ST_WR_EXP;
               idx_d   = 3'd0;
            end else if (need) begin
               phase_d = PH_REQ;
            end else begin
               advance = 1'b1;
            end
         end
         PH_REQ: begin
            if (req_rdy_i) phase_d = PH_RSP;
         end
         PH_RSP: begin
            if (rsp_val_i) begin
               if (!rsp_err_i) begin
                  retry_d = 8'd0;
                  commit  = 1'b1;
                  advance = 1'b1;
                  phase_d = PH_ISSUE;
               end else if (retry_q == 8'(MAX_RETRY)) begin
                  // Retries exhausted: abandon the pass and bring the devices back up.
                  err_d   = 1'b1;
                  retry_d = 8'd0;
                  state_d = ST_INIT_DIR;
                  idx_d   = 3'd0;
                  phase_d = PH_ISSUE;
                  inval   = 1'b1;
               end else begin
                  retry_d = retry_q + 8'd1;
                  phase_d = PH_REQ;
               end
            end
         end
         default: phase_d = PH_ISSUE;
      endcase

      if (advance) begin
         if (idx_q == last_idx) begin
            idx_d = 3'd0;
            case (state_q)
               ST_INIT_DIR:  state_d = ST_INIT_PU;
               ST_INIT_PU:   state_d = ST_INIT_DISP;
               ST_INIT_DISP: state_d = ST_SNAP;
               ST_WR_EXP:    state_d = ST_WR_DIG;
               ST_WR_DIG:    state_d = ST_RD_EXP;
               ST_RD_EXP: begin
                  state_d = ST_SNAP;
                  vld_d   = 1'b1;
               end
               default:      state_d = ST_IDLE;
            endcase
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   // Completed read pass: staged bytes plus the final response, MSB byte from expander 0.
   always_comb begin
      gpio_d = gpio_q;
      for (int e = 0; e < N_EXP; e++) begin
         gpio_d[8*(N_EXP-1-e) +: 8] = (idx_q == 3'(e)) ? rsp_data_i : stage_q[e];
      end
   end

   // Control state, sticky error, published switch values and shadow validity.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         phase_q  <= PH_ISSUE;
         idx_q    <= 3'd0;
         retry_q  <= 8'd0;
         err_q    <= 1'b0;
         vld_q    <= 1'b0;
         gpio_q   <= '0;
         exp_ok_q <= '0;
         dig_ok_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         retry_q <= retry_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         if (inval) begin
            exp_ok_q <= '0;
            dig_ok_q <= '0;
         end else if (commit && state_q == ST_WR_EXP) begin
            exp_ok_q[idx_q] <= 1'b1;
         end else if (commit && state_q == ST_WR_DIG) begin
            dig_ok_q[idx_q] <= 1'b1;
         end
         if (vld_d) gpio_q <= gpio_d;
      end
   end

   // Snapshot, shadow and staging storage for input and read data.
   always_ff @(posedge clk_i) begin
      // NOTE: data storage has no reset; the separately reset valid bits qualify every use.
      if (state_q == ST_SNAP) begin
         for (int e = 0; e < N_EXP; e++) snap_exp_q[e] <= gpio_i[8*(N_EXP-1-e) +: 8];
         for (int j = 0; j < N_DIG; j++) snap_dig_q[j] <= lcd_bcd_i[4*j +: 4];
      end
      if (commit) begin
         case (state_q)
            ST_WR_EXP: exp_shadow_q[idx_q] <= snap_exp_q[idx_q];
            ST_WR_DIG: dig_shadow_q[idx_q] <= snap_dig_q[idx_q];
            ST_RD_EXP: stage_q[idx_q]      <= rsp_data_i;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_panel_scan.sv
// tb_panel_scan: directed bench for panel_scan with hand-computed transactions.
module tb_panel_scan;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] gpio_i;
   logic [15:0] lcd_bcd_i;
   logic [31:0] gpio_o;
   logic        gpio_vld_o, err_o;
   logic        req_val_o, req_rdy_i;
   logic [6:0]  req_daddr_o;
   logic [7:0]  req_addr_o, req_data_o;
   logic        req_wen_o;
   logic        rsp_val_i, rsp_rdy_o, rsp_err_i;
   logic [7:0]  rsp_data_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] seg_pass1 [4] = '{8'h06, 8'h5B, 8'h4F, 8'h66};
   logic [7:0] rd_pass1  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] rd_pass2  [4] = '{8'h55, 8'h66, 8'h77, 8'h88};

   always #5 clk = ~clk;

   panel_scan #(
      .N_EXP     (4),
      .N_DIG     (4),
      .EXP_BASE  (7'h20),
      .DISP_ADDR (7'h70),
      .MAX_RETRY (3)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .gpio_i      (gpio_i),
      .lcd_bcd_i   (lcd_bcd_i),
      .gpio_o      (gpio_o),
      .gpio_vld_o  (gpio_vld_o),
      .err_o       (err_o),
      .req_val_o   (req_val_o),
      .req_rdy_i   (req_rdy_i),
      .req_daddr_o (req_daddr_o),
      .req_addr_o  (req_addr_o),
      .req_data_o  (req_data_o),
      .req_wen_o   (req_wen_o),
      .rsp_val_i   (rsp_val_i),
      .rsp_rdy_o   (rsp_rdy_o),
      .rsp_err_i   (rsp_err_i),
      .rsp_data_i  (rsp_data_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Wait for a request, compare {daddr, addr, data, wen}, accept it and answer it.
   task automatic expect_txn(input string tag, input logic [6:0] da, input logic [7:0] ad,
                             input logic [7:0] dt, input logic wn, input logic er,
                             input logic [7:0] rd);
      int n;
      n = 0;
      while (req_val_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (req_val_o !== 1'b1) begin
         check({tag, " req_val timeout"}, 32'(req_val_o), 32'd1);
         return;
      end
      check(tag, {8'h00, req_daddr_o, req_addr_o, req_data_o, req_wen_o},
            {8'h00, da, ad, dt, wn});
      req_rdy_i = 1'b1;
      @(negedge clk);
      req_rdy_i = 1'b0;
      n = 0;
      while (rsp_rdy_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (rsp_rdy_o !== 1'b1) begin
         check({tag, " rsp_rdy timeout"}, 32'(rsp_rdy_o), 32'd1);
         return;
      end
      rsp_val_i  = 1'b1;
      rsp_err_i  = er;
      rsp_data_i = rd;
      @(negedge clk);
      rsp_val_i  = 1'b0;
      rsp_err_i  = 1'b0;
      rsp_data_i = 8'h00;
   endtask

   task automatic expect_init(input string tag);
      for (int k = 0; k < 4; k++)
         expect_txn($sformatf("%s iodirb%0d", tag, k), 7'(32 + k), 8'h01, 8'h00, 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++)
         expect_txn($sformatf("%s gppua%0d", tag, k), 7'(32 + k), 8'h0C, 8'hFF, 1'b1, 1'b0, 8'h00);
      expect_txn({tag, " disp_on"}, 7'h70, 8'h21, 8'h81, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_val"},  32'(req_val_o),  32'd0);
      check({tag, " rsp_rdy"},  32'(rsp_rdy_o),  32'd0);
      check({tag, " gpio_o"},   gpio_o,          32'd0);
      check({tag, " gpio_vld"}, 32'(gpio_vld_o), 32'd0);
      check({tag, " err"},      32'(err_o),      32'd0);
   endtask

   initial begin
      int n;
      rst_i      = 1'b1;
      req_rdy_i  = 1'b0;
      rsp_val_i  = 1'b0;
      rsp_err_i  = 1'b0;
      rsp_data_i = 8'h00;
      gpio_i     = 32'hA500_0000;
      lcd_bcd_i  = 16'h4321;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");

      // IDLE for one cycle, request visible after the second edge.
      rst_i = 1'b0;
      @(posedge clk); #1;
      check("req_val after edge1", 32'(req_val_o), 32'd0);
      @(posedge clk); #1;
      check("req_val after edge2", 32'(req_val_o), 32'd1);
      @(negedge clk);

      expect_init("init");

      // Pass 1: every expander and digit is written after init.
      expect_txn("p1 olat0", 7'h20, 8'h15, 8'hA5, 1'b1, 1'b0, 8'h00);
      for (int k = 1; k < 4; k++)
         expect_txn($sformatf("p1 olat%0d", k), 7'(32 + k), 8'h15, 8'h00, 1'b1, 1'b0, 8'h00);
      for (int j = 0; j < 4; j++)
         expect_txn($sformatf("p1 dig%0d", j), 7'h70, 8'(2 * j), seg_pass1[j], 1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         expect_txn($sformatf("p1 rd%0d", k), 7'(32 + k), 8'h12, 8'h00, 1'b0, 1'b0, rd_pass1[k]);
         if (k == 2) check("p1 vld before last", 32'(gpio_vld_o), 32'd0);
      end
      check("p1 vld pulse", 32'(gpio_vld_o), 32'd1);
      check("p1 gpio_o", gpio_o, 32'h1122_3344);
      @(negedge clk);
      check("p1 vld drop", 32'(gpio_vld_o), 32'd0);

      // Pass 2: nothing dirty, so the first request is a read; inputs change mid-pass.
      expect_txn("p2 rd0", 7'h20, 8'h12, 8'h00, 1'b0, 1'b0, rd_pass2[0]);
      gpio_i    = 32'hA500_003C;
      lcd_bcd_i = 16'h4F21;
      for (int k = 1; k < 4; k++)
         expect_txn($sformatf("p2 rd%0d", k), 7'(32 + k), 8'h12, 8'h00, 1'b0, 1'b0, rd_pass2[k]);
      check("p2 vld pulse", 32'(gpio_vld_o), 32'd1);
      check("p2 gpio_o", gpio_o, 32'h5566_7788);

      // Pass 3: only expander 3 and digit 2 are dirty; the write is NACKed twice.
      for (int i = 0; i < 3; i++)
         expect_txn($sformatf("p3 retry%0d", i), 7'h23, 8'h15, 8'h3C, 1'b1, (i < 2), 8'h00);
      check("p3 err after retries", 32'(err_o), 32'd0);
      expect_txn("p3 dig2", 7'h70, 8'h04, 8'h71, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         expect_txn($sformatf("p3 rd nack%0d", i), 7'h20, 8'h12, 8'h00, 1'b0, 1'b1, 8'hEE);
         if (i == 2) check("p3 err before exhaust", 32'(err_o), 32'd0);
      end
      check("p3 err set", 32'(err_o), 32'd1);
      check("p3 gpio_o kept", gpio_o, 32'h5566_7788);
      check("p3 no vld", 32'(gpio_vld_o), 32'd0);

      // Re-init after the abandoned pass; shadows were invalidated so expander 0 is rewritten.
      expect_init("reinit");
      check("reinit err sticky", 32'(err_o), 32'd1);
      expect_txn("p4 olat0", 7'h20, 8'h15, 8'hA5, 1'b1, 1'b0, 8'h00);
      expect_txn("p4 olat1", 7'h21, 8'h15, 8'h00, 1'b1, 1'b0, 8'h00);

      // Reset while a request is pending and not accepted.
      n = 0;
      while (req_val_o !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("pending req_val", 32'(req_val_o), 32'd1);
      check("pending daddr", 32'(req_daddr_o), 32'h22);
      #2 rst_i = 1'b1;
      #1 check_reset_outputs("mid reset");
      @(negedge clk);
      rst_i = 1'b0;
      @(posedge clk); #1;
      check("restart edge1", 32'(req_val_o), 32'd0);
      @(negedge clk);
      expect_txn("restart iodirb0", 7'h20, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
